// File: rtl/seg_display_sequencer.sv
// -----------------------------------------------------------------------------
// seg_display_sequencer
//
// Takes a snapshot of NUM_DIGITS BCD digits plus blink controls on a start
// request and writes one 7-segment pattern per digit to consecutive Avalon-MM
// segment ports. Each write goes to BASE_ADDR + digit*ADDR_STRIDE. The last
// write is followed by a one-cycle done pulse.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   start            single-cycle update request (queued as pending if busy)
//   digits           BCD digits, digit i in bits [4i+3:4i]
//   blink_mask       per-digit blink enable
//   blink_phase      1 = blanked phase
//   avm_address      Avalon-MM byte address (0 when not writing)
//   avm_write        Avalon-MM write request
//   avm_writedata    {25'b0, active-low segments g..a} (0 when not writing)
//   avm_waitrequest  slave stall
//   busy             high in WRITE and DONE
//   done             one-cycle pulse when an update completes
//   dbg_state        current FSM state (0=IDLE, 1=WRITE, 2=DONE)
//
// Handshake: a transfer completes in a cycle where avm_write=1 and
// avm_waitrequest=0. While the slave stalls, address and data are held.
// They come from registered state only, so they cannot change during a stall.
// -----------------------------------------------------------------------------
module seg_display_sequencer #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic [15:0] ADDR_STRIDE = 16'h0010,
    parameter int          NUM_DIGITS  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blink_phase,
    output logic [15:0]             avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Three index bits cover the full legal range of 1..8 digits.
    localparam int            IW       = 3;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [IW-1:0]           index_q, index_d;
    logic                    pending_q, pending_d;
    logic                    snap_load;
    logic [4*NUM_DIGITS-1:0] snap_digits_q;
    logic [NUM_DIGITS-1:0]   snap_mask_q;
    logic                    snap_phase_q;

    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    logic [6:0]              cur_seg;

    // Active-low segments, bit0 = a .. bit6 = g. Non-BCD values are blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Pick the snapshot digit for the current index. A mux loop avoids a
    // variable part-select that could run past the vector when NUM_DIGITS < 8.
    always_comb begin
        cur_nibble = 4'hF;
        cur_blank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_q == IW'(i)) begin
                cur_nibble = snap_digits_q[4*i +: 4];
                cur_blank  = snap_mask_q[i] & snap_phase_q;
            end
        end
        cur_seg = cur_blank ? 7'h7F : bcd_to_seg(cur_nibble);
    end

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        pending_d     = pending_q;
        snap_load     = 1'b0;
        avm_write     = 1'b0;
        avm_address   = 16'h0000;
        avm_writedata = 32'h0000_0000;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_load = 1'b1;
                    index_d   = '0;
                    state_d   = WRITE;
                end
            end

            WRITE: begin
                busy          = 1'b1;
                avm_write     = 1'b1;
                avm_address   = BASE_ADDR + ({13'b0, index_q} * ADDR_STRIDE);
                avm_writedata = {25'b0, cur_seg};
                if (start) begin
                    pending_d = 1'b1;
                end
                if (!avm_waitrequest) begin
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + IW'(1);
                    end
                end
            end

            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                // A start arriving in this very cycle counts as pending, so
                // the next update follows with no idle gap.
                if (pending_q || start) begin
                    pending_d = 1'b0;
                    snap_load = 1'b1;
                    index_d   = '0;
                    state_d   = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            index_q       <= '0;
            pending_q     <= 1'b0;
            snap_digits_q <= '0;
            snap_mask_q   <= '0;
            snap_phase_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            pending_q <= pending_d;
            if (snap_load) begin
                snap_digits_q <= digits;
                snap_mask_q   <= blink_mask;
                snap_phase_q  <= blink_phase;
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_display_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for seg_display_sequencer (default parameters: base 0, stride 0x10,
// 6 digits). Expected {address, data} writes are queued when an update is
// launched and are popped by a monitor on each completed Avalon transfer.
// -----------------------------------------------------------------------------
module tb_seg_display_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] digits;
    logic [5:0]  blink_mask;
    logic        blink_phase;
    logic [15:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        wait_req;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q[$];

    typedef struct {
        logic [23:0]      digits;
        logic [5:0]       mask;
        logic             phase;
        logic [5:0][6:0]  exp_seg;   // element i = expected pattern of digit i
    } vec_t;

    vec_t vecs[6];

    seg_display_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .digits          (digits),
        .blink_mask      (blink_mask),
        .blink_phase     (blink_phase),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (wait_req),
        .busy            (busy),
        .done            (done),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_vec(input vec_t v);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({16'(i) * 16'h0010, 25'b0, v.exp_seg[i]});
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        stall_prev = 1'b0;
    logic [47:0] stall_val  = '0;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", {avm_address, avm_writedata}, stall_val);
            end
            if (!avm_write) begin
                check("idle_bus_zero", {avm_address, avm_writedata}, 48'h0);
            end
            if (avm_write && wait_req) begin
                stall_prev = 1'b1;
                stall_val  = {avm_address, avm_writedata};
            end else begin
                stall_prev = 1'b0;
            end
            if (avm_write && !wait_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {avm_address, avm_writedata}, 48'h0);
                    errors += (avm_address == 16'h0 && avm_writedata == 32'h0) ? 1 : 0;
                end else begin
                    check("write", {avm_address, avm_writedata}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers leave the bench just after a rising edge.
    // mode 0: no stall, 1: stall cycles 2..4 of the update, 2: random stalls.
    task automatic run_update(input vec_t v, input int mode, input int exp_cyc);
        int cyc;
        bit seen;
        push_vec(v);
        digits      = v.digits;
        blink_mask  = v.mask;
        blink_phase = v.phase;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs mid-update; the snapshot must shield the writes.
        digits      = 24'($urandom);
        blink_mask  = 6'($urandom);
        blink_phase = ~v.phase;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            case (mode)
                1:       wait_req = (cyc + 1 >= 2) && (cyc + 1 <= 4);
                2:       wait_req = ($urandom_range(0, 2) == 0);
                default: wait_req = 1'b0;
            endcase
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
            else      check("busy_during_update", busy, 1'b1);
            @(posedge clk); #1;
        end
        wait_req = 1'b0;
        check("done_seen", seen, 1'b1);
        if (exp_cyc > 0) check("done_latency", cyc, exp_cyc);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Runs an update and a second start at given cycles; expects two dones.
    task automatic run_double(input vec_t v1, input vec_t v2, input int s1, input int s2,
                              input int exp_first, input int exp_second);
        int cyc;
        int dones;
        int first;
        int second;
        push_vec(v1);
        push_vec(v2);
        digits      = v1.digits;
        blink_mask  = v1.mask;
        blink_phase = v1.phase;
        start       = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cyc    = 0;
        dones  = 0;
        first  = 0;
        second = 0;
        while (cyc < 30) begin
            start = (cyc + 1 == s1) || (cyc + 1 == s2);
            if (cyc + 1 == s1) begin
                digits      = v2.digits;
                blink_mask  = v2.mask;
                blink_phase = v2.phase;
            end
            @(negedge clk);
            cyc++;
            if (done) begin
                dones++;
                if (dones == 1) first = cyc;
                else if (dones == 2) second = cyc;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_pulses", dones, 2);
        check("first_done_cycle", first, exp_first);
        check("second_done_cycle", second, exp_second);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("busy_after_double", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{24'h012345, 6'b000000, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
        vecs[1] = '{24'h123456, 6'b000000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vecs[2] = '{24'hF00009, 6'b000001, 1'b1, {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F}};
        vecs[3] = '{24'h789ABC, 6'b000000, 1'b1, {7'h78, 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F}};
        vecs[4] = '{24'h678901, 6'b101010, 1'b1, {7'h7F, 7'h78, 7'h7F, 7'h10, 7'h7F, 7'h79}};
        vecs[5] = '{24'h678901, 6'b101010, 1'b0, {7'h02, 7'h78, 7'h00, 7'h10, 7'h40, 7'h79}};

        reset       = 1'b1;
        start       = 1'b0;
        digits      = '0;
        blink_mask  = '0;
        blink_phase = 1'b0;
        wait_req    = 1'b0;

        // Reset state, including a start that reset must override.
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("reset_write", avm_write, 1'b0);
        check("reset_bus", {avm_address, avm_writedata}, 48'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_state", dbg_state, 2'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            @(posedge clk); #1;
        end

        // Table-driven updates: clean bus, then randomly stalled bus.
        for (int i = 0; i < 6; i++) run_update(vecs[i], 0, 7);
        for (int i = 0; i < 6; i++) run_update(vecs[i], 2, 0);

        // Three stall cycles on the second transfer.
        run_update(vecs[0], 1, 10);

        // Pending restart: two starts mid-update collapse into one; the
        // restart snapshot picks up the all-zero digits.
        run_double(vecs[0], '{24'h000000, 6'b0, 1'b0,
                   {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}}, 3, 5, 7, 14);

        // Start landing exactly in the DONE cycle.
        run_double(vecs[1], vecs[2], 7, 0, 7, 14);

        // Reset during the third write while the slave stalls.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({16'(i) * 16'h0010, 25'b0, vecs[0].exp_seg[i]});
        end
        digits      = vecs[0].digits;
        blink_mask  = vecs[0].mask;
        blink_phase = vecs[0].phase;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            wait_req = (c >= 3);
            reset    = (c == 4);
            @(negedge clk);
            if (c == 3) check("third_write_addr", avm_address, 16'h0020);
            @(posedge clk); #1;
        end
        reset    = 1'b0;
        wait_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_reset_write", avm_write, 1'b0);
            check("post_reset_busy", busy, 1'b0);
            check("post_reset_done", done, 1'b0);
            @(posedge clk); #1;
        end
        check("reset_queue_drained", exp_q.size(), 0);

        // Normal operation resumes after the reset.
        run_update(vecs[3], 0, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
